// File: rtl/pcie_to_pc_fifo_if.sv
// Bus bundle for the to-PC FIFO: user word input port plus the block-write
// request/data port toward the TLP transmit engine.
interface pcie_to_pc_fifo_if;
    logic        i_valid;
    logic [63:0] i_data;
    logic        i_ready;
    logic        wr_valid;
    logic [7:0]  wr_tag;
    logic        wr_ready;
    logic        wr_data_valid;
    logic [63:0] wr_data;
    logic [5:0]  wr_index;
    logic        wr_last;
    logic        wr_data_ready;

    modport master (
        input  i_valid,
        input  i_data,
        output i_ready,
        output wr_valid,
        output wr_tag,
        input  wr_ready,
        output wr_data_valid,
        output wr_data,
        output wr_index,
        output wr_last,
        input  wr_data_ready
    );

    modport slave (
        output i_valid,
        output i_data,
        input  i_ready,
        input  wr_valid,
        input  wr_tag,
        output wr_ready,
        input  wr_data_valid,
        input  wr_data,
        input  wr_index,
        input  wr_last,
        output wr_data_ready
    );
endinterface

// File: rtl/pcie_to_pc_fifo.sv
// Host-bound FIFO channel: buffers 64-bit user words in an 8 x 64-word RAM and
// sends each full block to the TLP engine as one request plus 64 tagged words.
module pcie_to_pc_fifo (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        fifo_number,
    output logic [31:0]       status,
    pcie_to_pc_fifo_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_ram [0:511];
    logic [9:0]  r_p_in;
    logic [9:0]  r_p_commit;
    logic [6:0]  r_fetch_cnt;
    logic        r_rd_pend;
    logic [5:0]  r_rd_idx;
    logic [63:0] r_rd_data;
    logic [69:0] r_q0;
    logic [69:0] r_q1;
    logic [1:0]  r_q_cnt;
    logic        r_i_ready;
    logic        r_wr_valid;
    logic [22:0] r_blocks_sent;

    logic        w_accept;
    logic        w_pop;
    logic        w_last_xfer;
    logic        w_issue;
    logic [3:0]  w_full_blocks;
    logic [8:0]  w_rd_addr;
    logic [9:0]  w_p_in_next;
    logic [9:0]  w_commit_next;
    logic [9:0]  w_occ_next;
    logic [2:0]  w_credit;

    assign w_accept      = bus.i_valid & r_i_ready;
    assign w_pop         = (r_q_cnt != 2'd0) & bus.wr_data_ready;
    assign w_last_xfer   = w_pop & (r_q0[69:64] == 6'd63);
    assign w_full_blocks = r_p_in[9:6] - r_p_commit[9:6];
    assign w_rd_addr     = r_p_commit[8:0] + {3'b000, r_fetch_cnt[5:0]};
    assign w_p_in_next   = r_p_in + {9'd0, w_accept};
    assign w_commit_next = w_last_xfer ? (r_p_commit + 10'd64) : r_p_commit;
    assign w_occ_next    = w_p_in_next - w_commit_next;

    // Words already held or in flight after this cycle; keeps the skid stage from overflowing.
    assign w_credit = {1'b0, r_q_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_issue  = (r_state == ST_DATA) && !r_fetch_cnt[6] && (w_credit < 3'd2);

    assign bus.i_ready       = r_i_ready;
    assign bus.wr_valid      = r_wr_valid;
    assign bus.wr_tag        = {fifo_number, 3'b000, r_p_commit[8:6]};
    assign bus.wr_data_valid = (r_q_cnt != 2'd0);
    assign bus.wr_data       = r_q0[63:0];
    assign bus.wr_index      = r_q0[69:64];
    assign bus.wr_last       = (r_q_cnt != 2'd0) && (r_q0[69:64] == 6'd63);
    assign status            = {r_blocks_sent, 9'd0};

    // Block RAM: write port from the user side, registered read port for the block stream.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_ram[r_p_in[8:0]] <= bus.i_data;
        end
        r_rd_data <= r_ram[w_rd_addr];
    end

    // Buffer pointers, input-ready flag and delivered-block counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p_in        <= 10'd0;
            r_p_commit    <= 10'd0;
            r_i_ready     <= 1'b0;
            r_blocks_sent <= 23'd0;
        end else begin
            r_p_in     <= w_p_in_next;
            r_p_commit <= w_commit_next;
            r_i_ready  <= (w_occ_next < 10'd512);
            if (w_last_xfer) begin
                r_blocks_sent <= r_blocks_sent + 23'd1;
            end
        end
    end

    // State register and the request flag that mirrors the REQ state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wr_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_valid <= (w_state_next == ST_REQ);
        end
    end

    // Next-state logic; the block counter is checked before commit so "!= 1" means another block waits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_full_blocks != 4'd0) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.wr_ready) begin
                    w_state_next = ST_DATA;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DATA: begin
                if (w_last_xfer) begin
                    if (w_full_blocks != 4'd1) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Read-fetch counter and the one-cycle RAM read pipeline marker.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= 7'd0;
            r_rd_pend   <= 1'b0;
            r_rd_idx    <= 6'd0;
        end else begin
            if (r_state != ST_DATA) begin
                r_fetch_cnt <= 7'd0;
            end else if (w_issue) begin
                r_fetch_cnt <= r_fetch_cnt + 7'd1;
            end
            r_rd_pend <= w_issue;
            r_rd_idx  <= r_fetch_cnt[5:0];
        end
    end

    // Two-entry skid stage; q0 is always the word presented to the engine.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q0    <= 70'd0;
            r_q1    <= 70'd0;
            r_q_cnt <= 2'd0;
        end else begin
            case (r_q_cnt)
                2'd0: begin
                    if (r_rd_pend) begin
                        r_q0    <= {r_rd_idx, r_rd_data};
                        r_q_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({r_rd_pend, w_pop})
                        2'b11: r_q0 <= {r_rd_idx, r_rd_data};
                        2'b01: r_q_cnt <= 2'd0;
                        2'b10: begin
                            r_q1    <= {r_rd_idx, r_rd_data};
                            r_q_cnt <= 2'd2;
                        end
                        default: begin
                        end
                    endcase
                end
                2'd2: begin
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (r_rd_pend) begin
                            r_q1 <= {r_rd_idx, r_rd_data};
                        end else begin
                            r_q_cnt <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_q_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule
